// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response channel, decode-side
// instruction channel, next-address feedback and redirect.
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    // valid/ready: a transfer happens on a rising edge where both are 1; once
    // valid rises, the sender holds valid and its payload until that edge,
    // except when a redirect flushes the fetch stage.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;

    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_err;

    logic [XLEN-1:0] next_pc;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        output inst_valid, inst, inst_pc, inst_err,
        input  inst_ready,
        input  next_pc,
        input  redir_valid, redir_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
        input  inst_valid, inst, inst_pc, inst_err,
        output inst_ready,
        output next_pc,
        output redir_valid, redir_pc
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one memory read per PC, holds the
// fetched word for decode, and flushes on redirect.
module ifu_fetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    ifu_fetch_if.master bus,
    output logic [1:0]  state_o,
    output logic        drop_o
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic            aligned;

    assign aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        drop_d  = drop_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.redir_valid) pc_d = bus.redir_pc;
                state_d = S_REQ;
            end

            S_REQ: begin
                if (bus.redir_valid) begin
                    pc_d = bus.redir_pc;
                    // A request accepted this edge still owes a response; eat it.
                    if (aligned && bus.imem_req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end else if (!aligned) begin
                    inst_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.redir_valid) begin
                    pc_d = bus.redir_pc;
                    if (bus.imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = bus.imem_rsp_err ? 32'h0 : bus.imem_rsp_data;
                        err_d   = bus.imem_rsp_err;
                        state_d = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (bus.redir_valid) begin
                    pc_d    = bus.redir_pc;
                    state_d = S_REQ;
                end else if (bus.inst_ready) begin
                    pc_d    = bus.next_pc;
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.imem_req_valid = (state_q == S_REQ) && aligned;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = (state_q == S_HOLD);
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc_q;
    assign bus.inst_err       = err_q;

    assign state_o = state_q;
    assign drop_o  = drop_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: boot, sequential fetch, backpressure, redirects,
// faults and mid-flight reset, checked against hand-computed values.
module tb_ifu_fetch;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state;
    logic        drop;
    int          vectors;
    int          miscompares;
    int          req_cnt;
    int          req_base;
    logic [63:0] mem_addr;

    ifu_fetch_if #(.XLEN(64)) bus ();

    ifu_fetch #(.XLEN(64), .RESET_PC(64'h8000_0000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state),
        .drop_o  (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_cnt <= 0;
        else if (bus.imem_req_valid && bus.imem_req_ready) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic req_phase(input string tag, input logic [63:0] exp_addr);
        chk({tag, "_req_valid"}, 64'(bus.imem_req_valid), 64'd1);
        chk({tag, "_req_addr"}, bus.imem_req_addr, exp_addr);
        mem_addr = bus.imem_req_addr;
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        chk({tag, "_wait"}, 64'(state), 64'(ST_WAIT));
    endtask

    task automatic rsp_phase(input logic err);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_err   = err;
        bus.imem_rsp_data  = mem_addr[31:0] ^ 32'hA5A5_A5A5;
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        bus.imem_rsp_data  = 32'h0;
    endtask

    task automatic hold_check(input string tag, input logic [31:0] exp_inst,
                              input logic [63:0] exp_pc, input logic exp_err);
        chk({tag, "_inst_valid"}, 64'(bus.inst_valid), 64'd1);
        chk({tag, "_inst"}, 64'(bus.inst), 64'(exp_inst));
        chk({tag, "_inst_pc"}, bus.inst_pc, exp_pc);
        chk({tag, "_inst_err"}, 64'(bus.inst_err), 64'(exp_err));
    endtask

    task automatic accept(input logic [63:0] nxt);
        bus.inst_ready = 1'b1;
        bus.next_pc    = nxt;
        step();
        bus.inst_ready = 1'b0;
        bus.next_pc    = 64'h0;
    endtask

    initial begin
        vectors              = 0;
        miscompares          = 0;
        mem_addr             = 64'h0;
        bus.imem_req_ready   = 1'b0;
        bus.imem_rsp_valid   = 1'b0;
        bus.imem_rsp_data    = 32'h0;
        bus.imem_rsp_err     = 1'b0;
        bus.inst_ready       = 1'b0;
        bus.next_pc          = 64'h0;
        bus.redir_valid      = 1'b0;
        bus.redir_pc         = 64'h0;
        rst_n                = 1'b0;

        // Boot
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
            chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        end
        chk("rst_state", 64'(state), 64'(ST_IDLE));
        chk("rst_addr", bus.imem_req_addr, 64'h8000_0000);
        chk("rst_inst_pc", bus.inst_pc, 64'h8000_0000);
        chk("rst_inst", 64'(bus.inst), 64'h0);
        chk("rst_drop", 64'(drop), 64'd0);
        rst_n = 1'b1;
        step();

        // Sequential fetch, one instruction every 3 cycles
        req_phase("seq0", 64'h8000_0000);
        rsp_phase(1'b0);
        hold_check("seq0", 32'h25A5_A5A5, 64'h8000_0000, 1'b0);
        accept(64'h8000_0004);
        req_phase("seq1", 64'h8000_0004);
        rsp_phase(1'b0);
        hold_check("seq1", 32'h25A5_A5A1, 64'h8000_0004, 1'b0);
        accept(64'h8000_0008);
        req_phase("seq2", 64'h8000_0008);
        rsp_phase(1'b0);
        hold_check("seq2", 32'h25A5_A5AD, 64'h8000_0008, 1'b0);
        accept(64'h8000_000C);

        // Backpressure on both channels
        req_base = req_cnt;
        for (int i = 0; i < 4; i++) begin
            chk("bp_req_valid", 64'(bus.imem_req_valid), 64'd1);
            chk("bp_req_addr", bus.imem_req_addr, 64'h8000_000C);
            step();
        end
        req_phase("bp", 64'h8000_000C);
        rsp_phase(1'b0);
        bus.next_pc = 64'hDEAD_BEEF_0000_0000;
        for (int i = 0; i < 5; i++) begin
            hold_check("bp_hold", 32'h25A5_A5A9, 64'h8000_000C, 1'b0);
            step();
        end
        accept(64'h8000_0010);
        chk("bp_one_req", 64'(req_cnt - req_base), 64'd1);

        // Redirect while waiting; stale response must be dropped
        req_phase("rw", 64'h8000_0010);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h8000_0100;
        step();
        bus.redir_valid = 1'b0;
        chk("rw_drop", 64'(drop), 64'd1);
        chk("rw_addr", bus.imem_req_addr, 64'h8000_0100);
        for (int i = 0; i < 2; i++) begin
            chk("rw_state", 64'(state), 64'(ST_WAIT));
            chk("rw_req_valid", 64'(bus.imem_req_valid), 64'd0);
            step();
        end
        rsp_phase(1'b0);
        chk("rw_no_inst", 64'(bus.inst_valid), 64'd0);
        chk("rw_state_req", 64'(state), 64'(ST_REQ));
        chk("rw_drop_clr", 64'(drop), 64'd0);

        // Redirect and handshake in the same HOLD cycle
        req_phase("rh", 64'h8000_0100);
        rsp_phase(1'b0);
        hold_check("rh", 32'h25A5_A4A5, 64'h8000_0100, 1'b0);
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h8000_0200;
        accept(64'h8000_0004);
        bus.redir_valid = 1'b0;
        chk("rh_inst_valid", 64'(bus.inst_valid), 64'd0);
        req_phase("rh_new", 64'h8000_0200);
        rsp_phase(1'b0);
        hold_check("rh_new", 32'h25A5_A7A5, 64'h8000_0200, 1'b0);

        // Misaligned PC: no request, fault reported next cycle
        accept(64'h8000_0006);
        req_base = req_cnt;
        chk("mis_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("mis_state", 64'(state), 64'(ST_REQ));
        step();
        hold_check("mis", 32'h0, 64'h8000_0006, 1'b1);
        chk("mis_no_req", 64'(req_cnt - req_base), 64'd0);
        accept(64'h8000_0008);

        // Access fault on the response
        req_phase("afe", 64'h8000_0008);
        rsp_phase(1'b1);
        hold_check("afe", 32'h0, 64'h8000_0008, 1'b1);
        accept(64'h8000_0010);

        // Reset pulsed in WAIT
        req_phase("rstw", 64'h8000_0010);
        rst_n = 1'b0;
        #1;
        chk("rstw_state", 64'(state), 64'(ST_IDLE));
        chk("rstw_pc", bus.imem_req_addr, 64'h8000_0000);
        chk("rstw_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rstw_err", 64'(bus.inst_err), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstw_boot_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("rstw_boot_addr", bus.imem_req_addr, 64'h8000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
